fft_src_burst_reader: RTL and testbench

//  Burst read sequencer for the single-port registered sample memory (dram_16x1024 style: addr + clk_en,
//  rd_data registered one cycle after clk_en). On a start pulse it reads burst_len consecutive words from

---
 rtl/fft_src_pkg.sv | 31 +++
 rtl/fft_src_skid_fifo.sv | 70 +++++++
 rtl/fft_src_burst_reader.sv | 183 ++++++++++++++++++
 tb/tb_fft_src_burst_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_src_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fft_src_pkg                                                  |
// | Description : Shared definitions for the FFT source burst reader: FSM      |
// |               state encoding and the address bit-reverse helper.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fft_src_pkg;

    // Burst sequencer states.
    // IDLE  : waiting for a start request.
    // RUN   : reads still being issued to the memory.
    // DRAIN : all reads issued; waiting for the final word to leave the stream.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Reverse the low 'width' bits of 'value'; bits above 'width' come back zero.
    // Used to turn a natural-order read counter into a bit-reversed address
    // offset, so a DIT FFT receives its input in bit-reversed order.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] rev;
        rev = '0;
        for (int i = 0; i < 32; i++) begin
            rev[i] = value[31 - i];
        end
        return rev >> (32 - width);
    endfunction

endpackage : fft_src_pkg
`default_nettype wire

// File: rtl/fft_src_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_src_skid_fifo                                            |
// | Description : Two-entry FIFO holding {last, data} words returned by the    |
// |               memory while the downstream stream is stalled. The head      |
// |               entry stays put until it is popped, so the stream output is  |
// |               stable under backpressure.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_src_skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic [1:0]       o_count,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO or a pop from an empty one is dropped rather
    // than corrupting the pointers; the issue logic upstream never does either.
    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop  && (r_count != 2'd0);

    // Storage slots, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot0  <= '0;
            r_slot1  <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                if (r_wr_ptr) begin
                    r_slot1 <= i_push_data;
                end else begin
                    r_slot0 <= i_push_data;
                end
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_rd_ptr ? r_slot1 : r_slot0;
    assign o_count     = r_count;
    assign o_valid     = (r_count != 2'd0);

endmodule : fft_src_skid_fifo
`default_nettype wire

// File: rtl/fft_src_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_src_burst_reader                                         |
// | Description : Burst read sequencer for a single-port registered sample     |
// |               memory. On start it reads burst_len consecutive words from   |
// |               base_addr and presents them as a valid/ready stream with a   |
// |               last flag. Reads are only issued when the skid FIFO can hold |
// |               the returning word, so backpressure never loses data.        |
// |               Build option BITREV_ADDR_EN: burst length fixed to the full  |
// |               memory depth and the read offset is bit-reversed.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_src_burst_reader
    import fft_src_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_clk_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    // Memory depth expressed in the burst length width (2**ADDR_WIDTH).
    localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Sequencer state and burst context
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issue_cnt;

    // Read pipeline: a read issued this cycle returns data next cycle
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;

    logic [ADDR_WIDTH:0]   w_len_req;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_issue_last;
    logic [2:0]            w_occupancy;
    logic [ADDR_WIDTH-1:0] w_offset;

    // Skid FIFO interface
    logic [DATA_WIDTH:0]   w_fifo_head;
    logic [1:0]            w_fifo_cnt;
    logic                  w_fifo_valid;
    logic                  w_head_last;
    logic                  w_pop;

    // ------------------------------------------------------------------------
    // Requested burst length and read address offset
    // ------------------------------------------------------------------------
`ifdef BITREV_ADDR_EN
    // Full-memory bit-reversed sweep: the requested length is irrelevant.
    logic w_unused_burst_len;
    assign w_unused_burst_len = ^burst_len;
    assign w_len_req = c_DEPTH;
    assign w_offset  = ADDR_WIDTH'(bitrev({{(32 - ADDR_WIDTH){1'b0}}, r_issue_cnt[ADDR_WIDTH-1:0]},
                                          ADDR_WIDTH));
`else
    // Lengths beyond the memory depth are clamped to one full sweep.
    assign w_len_req = (burst_len > c_DEPTH) ? c_DEPTH : burst_len;
    assign w_offset  = r_issue_cnt[ADDR_WIDTH-1:0];
`endif

    // Address arithmetic wraps naturally modulo the memory depth.
    assign mem_addr = r_base + w_offset;

    // ------------------------------------------------------------------------
    // Issue control
    // ------------------------------------------------------------------------
    // Words already owned by this block (in the FIFO or in flight from the
    // memory) minus the one leaving this cycle; a new read is allowed only
    // while that stays below the FIFO capacity of two.
    assign w_pop        = w_fifo_valid && m_ready;
    assign w_occupancy  = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == c_ST_RUN) && (r_issue_cnt < r_len) && (w_occupancy < 3'd2);
    assign w_issue_last = (r_issue_cnt == (r_len - c_ONE));
    assign w_accept     = (r_state == c_ST_IDLE) && start && (w_len_req != '0);

    assign mem_clk_en   = w_issue;

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start a burst, finish issuing, then wait for the last word to leave.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_issue && w_issue_last) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Burst context, issue counter, in-flight tracking and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base          <= '0;
            r_len           <= '0;
            r_issue_cnt     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;
            r_done          <= (r_state == c_ST_DRAIN) && w_pop && w_head_last;
            if (w_accept) begin
                r_base      <= base_addr;
                r_len       <= w_len_req;
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + c_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Returned words are tagged with their last flag and queued for the stream
    // ------------------------------------------------------------------------
    fft_src_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, mem_rd_data}),
        .i_pop       (w_pop),
        .o_head_data (w_fifo_head),
        .o_count     (w_fifo_cnt),
        .o_valid     (w_fifo_valid)
    );

    assign w_head_last = w_fifo_head[DATA_WIDTH];

    assign m_valid = w_fifo_valid;
    assign m_data  = w_fifo_head[DATA_WIDTH-1:0];
    assign m_last  = w_fifo_valid && w_head_last;
    assign busy    = (r_state != c_ST_IDLE);
    assign done    = r_done;

endmodule : fft_src_burst_reader
`default_nettype wire

// File: tb/tb_fft_src_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_src_burst_reader                                      |
// | Description : Self-checking bench for fft_src_burst_reader with a          |
// |               registered memory model loaded with mem[i]=i. A queue-based  |
// |               model predicts read addresses, stream words and done/busy.   |
// |               BITREV_ADDR_EN selects the bit-reversed 8-word build.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_src_burst_reader;

`ifdef BITREV_ADDR_EN
    localparam int AW = 3;
`else
    localparam int AW = 10;
`endif
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   burst_len;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_clk_en;
    logic [DW-1:0] mem_rd_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    logic [DW-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [DW:0]   exp_q[$];
    int            exp_addr_q[$];
    logic          exp_busy;
    logic          exp_done;
    int            outstanding;
    logic          pop_now;
    logic          nxt_busy;
    logic          nxt_done;
    logic [DW:0]   ent;

    // Observed stream
    logic [DW-1:0] got[$];
    logic [DW-1:0] last_data;
    int            n_last;
    int            cyc;

    fft_src_burst_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_clk_en  (mem_clk_en),
        .mem_rd_data (mem_rd_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // Registered single-port memory: data appears the cycle after clk_en.
    always @(posedge clk) begin
        if (mem_clk_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic int rev_bits(input int k);
        int r;
        r = 0;
        for (int i = 0; i < AW; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (AW - 1 - i));
        end
        return r;
    endfunction

    // Expected burst: the list of addresses in read order; data equals address.
    task automatic model_start(input int b, input int l);
        int len;
        int a;
        len = l;
        if (len > DEPTH) len = DEPTH;
`ifdef BITREV_ADDR_EN
        len = DEPTH;
`endif
        if (len != 0) begin
            for (int k = 0; k < len; k++) begin
`ifdef BITREV_ADDR_EN
                a = (b + rev_bits(k)) % DEPTH;
`else
                a = (b + k) % DEPTH;
`endif
                exp_addr_q.push_back(a);
                exp_q.push_back({(k == len - 1), a[DW-1:0]});
            end
            nxt_busy    = 1'b1;
            outstanding = 0;
        end
    endtask

    // Compare process: checks every cycle at the falling edge, then advances the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_addr_q.delete();
            exp_busy    = 1'b0;
            exp_done    = 1'b0;
            outstanding = 0;
        end else begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            pop_now  = m_valid && m_ready;
            nxt_busy = exp_busy;
            nxt_done = 1'b0;
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("valid_without_expected_word", m_valid, 0);
                end else begin
                    chk("m_data", m_data, exp_q[0][DW-1:0]);
                    chk("m_last", m_last, exp_q[0][DW]);
                end
            end
            if (mem_clk_en) begin
                chk("occupancy_below_two", ((outstanding - int'(pop_now)) < 2), 1);
                if (exp_addr_q.size() == 0) chk("read_beyond_burst", mem_clk_en, 0);
                else                        chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (pop_now && exp_q.size() != 0) begin
                ent = exp_q.pop_front();
                got.push_back(ent[DW-1:0]);
                outstanding--;
                if (ent[DW]) begin
                    nxt_busy  = 1'b0;
                    nxt_done  = 1'b1;
                    last_data = ent[DW-1:0];
                    n_last++;
                end
            end
            if (mem_clk_en) outstanding++;
            if (start && !exp_busy) model_start(int'(base_addr), int'(burst_len));
            exp_busy = nxt_busy;
            exp_done = nxt_done;
        end
    end

    // Pulse start, then run until done; mode 1 toggles m_ready with a 5-cycle stall.
    task automatic run_burst(input int b, input int l, input int mode);
        int c;
        got.delete();
        n_last    = 0;
        start     = 1'b1;
        base_addr = AW'(b);
        burst_len = (AW + 1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        while (!done && c < 3000) begin
            if (mode == 1) m_ready = (c >= 6 && c < 11) ? 1'b0 : c[0];
            @(posedge clk); #1;
            c++;
        end
        m_ready = 1'b1;
        chk("burst_completes", done, 1);
        cyc = c;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        burst_len = '0;
        m_ready   = 1'b1;
        n_last    = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = i[DW-1:0];
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_mem_clk_en", mem_clk_en, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_m_data", m_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef BITREV_ADDR_EN
        begin
            int t6[8];
            t6 = '{0, 4, 2, 6, 1, 5, 3, 7};
            run_burst(0, 0, 0);
            chk("t6_count", got.size(), 8);
            for (int i = 0; i < 8 && i < got.size(); i++) chk("t6_word", got[i], t6[i]);
            chk("t6_last_data", last_data, 7);
            chk("t6_cycles", cyc, 11);
        end
`else
        // 1: base 0, len 8, ready held high; latency and start-to-done pinned.
        got.delete();
        n_last    = 0;
        start     = 1'b1;
        base_addr = '0;
        burst_len = 11'd8;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t1_busy_E0", busy, 1);
        chk("t1_valid_E0", m_valid, 0);
        @(posedge clk); #1;
        chk("t1_valid_E1", m_valid, 0);
        @(posedge clk); #1;
        chk("t1_valid_E2", m_valid, 1);
        chk("t1_first_data", m_data, 0);
        cyc = 3;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t1_start_to_done", cyc, 11);
        chk("t1_count", got.size(), 8);
        chk("t1_word5", got[5], 5);
        chk("t1_last_data", last_data, 7);

        // 2: address wrap past the top of memory.
        run_burst(1020, 8, 0);
        chk("t2_count", got.size(), 8);
        chk("t2_first", got[0], 1020);
        chk("t2_word3", got[3], 1023);
        chk("t2_wrap", got[4], 0);
        chk("t2_last_data", last_data, 3);
        chk("t2_cycles", cyc, 11);

        // 3: toggling ready plus a 5-cycle stall.
        run_burst(0, 16, 1);
        chk("t3_count", got.size(), 16);
        chk("t3_word9", got[9], 9);
        chk("t3_last_data", last_data, 15);
        chk("t3_single_last", n_last, 1);

        // 4: start while busy is ignored; len 0 start in the done cycle is ignored.
        got.delete();
        n_last    = 0;
        start     = 1'b1;
        base_addr = '0;
        burst_len = 11'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 10'd100;
        burst_len = 11'd4;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t4_done_seen", done, 1);
        start     = 1'b1;
        base_addr = 10'd5;
        burst_len = 11'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_len0_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_count", got.size(), 8);
        chk("t4_word7", got[7], 7);
        chk("t4_single_last", n_last, 1);
        chk("t4_idle_after", busy, 0);

        // 5: reset after four words of a 32-word burst, then a fresh burst.
        got.delete();
        start     = 1'b1;
        base_addr = '0;
        burst_len = 11'd32;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (got.size() < 4 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t5_four_words", got.size(), 4);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_mem_clk_en", mem_clk_en, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_m_last", m_last, 0);
        chk("t5_rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_burst(0, 4, 0);
        chk("t5_count", got.size(), 4);
        chk("t5_first", got[0], 0);
        chk("t5_last_data", last_data, 3);
        chk("t5_cycles", cyc, 7);

        // Clamp: a length above the depth reads exactly one full sweep.
        run_burst(0, 1025, 0);
        chk("clamp_count", got.size(), 1024);
        chk("clamp_last_data", last_data, 1023);
        chk("clamp_cycles", cyc, 1027);
`endif

        repeat (5) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fft_src_burst_reader
`default_nettype wire
